// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers
// for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int MAX_HOLD_DEF = 4;
  localparam int HCNT_W       = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } state_t;

  function automatic logic [SEL_W-1:0] next_idx(
    input logic [SEL_W-1:0] idx
  );
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/arbiter bundle: req, last in;
// grant, grant_valid, sel, timeout out.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             last;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [SEL_W-1:0] sel;
  logic             timeout;

  modport master (
    output req, last,
    input  grant, grant_valid, sel, timeout
  );

  modport slave (
    input  req, last,
    output grant, grant_valid, sel, timeout
  );

endinterface

// File: rtl/mux_rr_arbiter_prio_pick.sv
// Rotating priority search: first set req bit
// from i_ptr upward with wrap; o_found/o_win_idx.
module rr_prio_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_win_idx
);

  logic [N_REQ-1:0] w_rot;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] =
        i_req[SEL_W'((i + int'(i_ptr)) % N_REQ)];
    end
  end

  // Descending scan: lowest set slot wins,
  // then map back to the requester index.
  always_comb begin
    o_found   = |i_req;
    o_win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_win_idx =
          SEL_W'((i + int'(i_ptr)) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select.
// Ports: clk, rst, bus (slave: req/last in, grant out).
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
(
  input  logic            clk,
  input  logic            rst,
  mux_rr_arbiter_if.slave bus
);

  localparam logic [HCNT_W-1:0] HOLD_LAST =
    HCNT_W'(MAX_HOLD - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  r_sel;
  logic [HCNT_W-1:0] r_hcnt;
  logic [N_REQ-1:0]  r_grant;
  logic              r_gv;
  logic              r_to;

  logic              w_busy;
  logic              w_hit;
  logic              w_own_req;
  logic              w_end;
  logic              w_to;
  logic [SEL_W-1:0]  w_nptr;
  logic [SEL_W-1:0]  w_pick_ptr;
  logic              w_found;
  logic [SEL_W-1:0]  w_win;

  assign w_busy    = (r_state == S_BUSY);
  assign w_hit     = (r_hcnt == HOLD_LAST);
  assign w_own_req = bus.req[r_sel];
  assign w_end     = w_busy &
    (bus.last | ~w_own_req | w_hit);
  // Only a pure hold-limit expiry is a timeout.
  assign w_to      = w_hit & ~bus.last & w_own_req;
  assign w_nptr    = next_idx(r_sel);
  // On an end, search from the owner's successor
  // so the owner ranks last.
  assign w_pick_ptr = w_end ? w_nptr : r_ptr;

  rr_prio_pick u_pick (
    .i_req     (bus.req),
    .i_ptr     (w_pick_ptr),
    .o_found   (w_found),
    .o_win_idx (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_hcnt  <= '0;
      r_grant <= '0;
      r_gv    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_to <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BUSY;
            r_grant <= N_REQ'(1) << w_win;
            r_sel   <= w_win;
            r_gv    <= 1'b1;
            r_hcnt  <= '0;
          end
        end
        S_BUSY: begin
          if (!w_end) begin
            r_hcnt <= r_hcnt + HCNT_W'(1);
          end else begin
            r_ptr <= w_nptr;
            r_to  <= w_to;
            r_hcnt <= '0;
            if (w_found) begin
              r_grant <= N_REQ'(1) << w_win;
              r_sel   <= w_win;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_gv    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_gv;
  assign bus.sel         = r_sel;
  assign bus.timeout     = r_to;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: dut (hold 4) and dut1 (hold 1)
// with a bench-side 8:1 mux on dut1's select.
module tb_mux_rr_arbiter;
  import mux_rr_arbiter_pkg::*;

  typedef struct {
    int         cyc;
    bit         b;
    logic [7:0] g;
    logic [2:0] s;
    bit         to;
    bit         m;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  logic [7:0] mux_in = 8'b1010_0101;
  logic       mux_out;

  mux_rr_arbiter_if bus_a ();
  mux_rr_arbiter_if bus_b ();

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign mux_out = mux_in[bus_b.sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string nm, input int c,
    input int act, input int exp
  );
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.b) begin
        chk("b_grant", e.cyc, bus_b.grant, e.g);
        chk("b_sel", e.cyc, bus_b.sel, e.s);
        chk("b_valid", e.cyc,
            bus_b.grant_valid, e.g != 0);
        chk("b_tout", e.cyc, bus_b.timeout, e.to);
        chk("b_mux", e.cyc, mux_out, e.m);
      end else begin
        chk("a_grant", e.cyc, bus_a.grant, e.g);
        chk("a_sel", e.cyc, bus_a.sel, e.s);
        chk("a_valid", e.cyc,
            bus_a.grant_valid, e.g != 0);
        chk("a_tout", e.cyc, bus_a.timeout, e.to);
      end
    end
  end

  task automatic step(
    input bit b, input bit r,
    input logic [7:0] rq, input bit l,
    input logic [7:0] eg, input logic [2:0] es,
    input bit et, input bit em
  );
    exp_t e;
    rst = r;
    bus_a.req  = b ? 8'h00 : rq;
    bus_a.last = b ? 1'b0 : l;
    bus_b.req  = b ? rq : 8'h00;
    bus_b.last = 1'b0;
    e.cyc = cyc + 1;
    e.b = b; e.g = eg; e.s = es;
    e.to = et; e.m = em;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic a(
    input bit r, input logic [7:0] rq,
    input bit l, input logic [7:0] eg,
    input logic [2:0] es, input bit et
  );
    step(1'b0, r, rq, l, eg, es, et, 1'b0);
  endtask

  task automatic bb(
    input logic [7:0] rq, input logic [7:0] eg,
    input logic [2:0] es, input bit et,
    input bit em
  );
    step(1'b1, 1'b0, rq, 1'b0, eg, es, et, em);
  endtask

  initial begin
    // reset state
    a(1, 8'h00, 0, 8'h00, 0, 0);
    // sole requester, last on 3rd grant cycle
    a(0, 8'h20, 0, 8'h20, 5, 0);
    a(0, 8'h20, 0, 8'h20, 5, 0);
    a(0, 8'h20, 0, 8'h20, 5, 0);
    a(0, 8'h20, 1, 8'h20, 5, 0);
    a(0, 8'h00, 0, 8'h00, 5, 0);
    // reset mid-grant
    a(0, 8'h04, 0, 8'h04, 2, 0);
    a(1, 8'h04, 0, 8'h00, 0, 0);
    a(0, 8'h04, 0, 8'h04, 2, 0);
    a(0, 8'h00, 0, 8'h00, 2, 0);
    a(1, 8'h00, 0, 8'h00, 0, 0);
    // rotation with wrap 0 -> 7 -> 0
    a(0, 8'h81, 0, 8'h01, 0, 0);
    a(0, 8'h81, 0, 8'h01, 0, 0);
    a(0, 8'h81, 1, 8'h80, 7, 0);
    a(0, 8'h81, 0, 8'h80, 7, 0);
    a(0, 8'h81, 1, 8'h01, 0, 0);
    a(0, 8'h81, 0, 8'h01, 0, 0);
    a(0, 8'h81, 1, 8'h80, 7, 0);
    a(0, 8'h00, 0, 8'h00, 7, 0);
    // hold-limit timeouts
    for (int i = 0; i < 4; i++)
      a(0, 8'h06, 0, 8'h02, 1, 0);
    a(0, 8'h06, 0, 8'h04, 2, 1);
    for (int i = 0; i < 3; i++)
      a(0, 8'h06, 0, 8'h04, 2, 0);
    a(0, 8'h06, 0, 8'h02, 1, 1);
    for (int i = 0; i < 3; i++)
      a(0, 8'h06, 0, 8'h02, 1, 0);
    // last together with hold limit: no timeout
    a(0, 8'h06, 1, 8'h04, 2, 0);
    a(0, 8'h00, 0, 8'h00, 2, 0);
    // owner 3 drops its request
    a(0, 8'h48, 0, 8'h08, 3, 0);
    a(0, 8'h48, 0, 8'h08, 3, 0);
    a(0, 8'h40, 0, 8'h40, 6, 0);
    a(0, 8'h00, 0, 8'h00, 6, 0);
    // hold 1: per-cycle rotation through mux
    bb(8'hFF, 8'h01, 0, 0, 1);
    bb(8'hFF, 8'h02, 1, 1, 0);
    bb(8'hFF, 8'h04, 2, 1, 1);
    bb(8'hFF, 8'h08, 3, 1, 0);
    bb(8'hFF, 8'h10, 4, 1, 0);
    bb(8'hFF, 8'h20, 5, 1, 1);
    bb(8'hFF, 8'h40, 6, 1, 0);
    bb(8'hFF, 8'h80, 7, 1, 1);
    bb(8'hFF, 8'h01, 0, 1, 1);
    bb(8'h00, 8'h00, 0, 0, 1);
    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain left=%0d exp=0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
